// File: rtl/fust_issue_table.sv
// Function-unit status table: one row per FU, holds a dispatched op until
// its sources are ready, issues round-robin and frees the row on writeback.
module fust_issue_table #(
    parameter int NUM_FU = 4,
    parameter int OP_W   = 5,
    parameter int REG_W  = 5,
    localparam int FU_W  = $clog2(NUM_FU)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              disp_en,
    input  logic [FU_W-1:0]   disp_fu,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic [REG_W-1:0]  disp_rs1,
    input  logic [REG_W-1:0]  disp_rs2,
    input  logic [FU_W-1:0]   disp_q1,
    input  logic [FU_W-1:0]   disp_q2,
    input  logic              disp_r1,
    input  logic              disp_r2,
    output logic [NUM_FU-1:0] busy,
    input  logic              wb_en,
    input  logic [FU_W-1:0]   wb_fu,
    input  logic              flush,
    input  logic              freeze,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [FU_W-1:0]   iss_fu,
    output logic [OP_W-1:0]   iss_op,
    output logic [REG_W-1:0]  iss_rd,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        ISSUED = 2'd2
    } row_st_e;

    row_st_e           st     [NUM_FU];
    logic [OP_W-1:0]   op_q   [NUM_FU];
    logic [REG_W-1:0]  rd_q   [NUM_FU];
    logic [REG_W-1:0]  rs1_q  [NUM_FU];
    logic [REG_W-1:0]  rs2_q  [NUM_FU];
    logic [FU_W-1:0]   q1_q   [NUM_FU];
    logic [FU_W-1:0]   q2_q   [NUM_FU];
    logic [NUM_FU-1:0] r1_q;
    logic [NUM_FU-1:0] r2_q;
    logic [FU_W-1:0]   rr_ptr;

    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] freed;
    logic [NUM_FU-1:0] disp_hit;
    logic [FU_W-1:0]   sel;
    logic [FU_W-1:0]   sel_nxt;
    logic [FU_W:0]     idx;
    logic              any_elig;
    logic              disp_ok;
    logic              hs;

    assign disp_ok = disp_en & ~freeze & ~flush;

    // A row freed by this cycle's writeback may be re-dispatched at once
    always_comb begin
        busy     = '0;
        elig     = '0;
        freed    = '0;
        disp_hit = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            busy[k]     = (st[k] != FREE);
            elig[k]     = (st[k] == WAIT) & r1_q[k] & r2_q[k];
            freed[k]    = wb_en & (wb_fu == FU_W'(k)) & (st[k] == ISSUED);
            disp_hit[k] = disp_ok & (disp_fu == FU_W'(k))
                        & ((st[k] == FREE) | freed[k]);
        end
    end

    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = {1'b0, rr_ptr} + (FU_W+1)'(i);
            if (idx >= (FU_W+1)'(NUM_FU))
                idx = idx - (FU_W+1)'(NUM_FU);
            if (!any_elig && elig[idx[FU_W-1:0]]) begin
                any_elig = 1'b1;
                sel      = idx[FU_W-1:0];
            end
        end
    end

    assign sel_nxt   = (sel == FU_W'(NUM_FU-1)) ? '0 : sel + FU_W'(1);
    assign iss_valid = any_elig & ~freeze & ~flush;
    assign hs        = iss_valid & iss_ready;

    assign iss_fu  = iss_valid ? sel        : '0;
    assign iss_op  = iss_valid ? op_q[sel]  : '0;
    assign iss_rd  = iss_valid ? rd_q[sel]  : '0;
    assign iss_rs1 = iss_valid ? rs1_q[sel] : '0;
    assign iss_rs2 = iss_valid ? rs2_q[sel] : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NUM_FU; k++) begin
                st[k]    <= FREE;
                op_q[k]  <= '0;
                rd_q[k]  <= '0;
                rs1_q[k] <= '0;
                rs2_q[k] <= '0;
                q1_q[k]  <= '0;
                q2_q[k]  <= '0;
            end
            r1_q   <= '0;
            r2_q   <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            for (int k = 0; k < NUM_FU; k++)
                st[k] <= FREE;
            r1_q   <= '0;
            r2_q   <= '0;
            rr_ptr <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (disp_hit[k]) begin
                    st[k]    <= WAIT;
                    op_q[k]  <= disp_op;
                    rd_q[k]  <= disp_rd;
                    rs1_q[k] <= disp_rs1;
                    rs2_q[k] <= disp_rs2;
                    q1_q[k]  <= disp_q1;
                    q2_q[k]  <= disp_q2;
                    r1_q[k]  <= disp_r1 | (wb_en & (disp_q1 == wb_fu));
                    r2_q[k]  <= disp_r2 | (wb_en & (disp_q2 == wb_fu));
                end else begin
                    if (freed[k])
                        st[k] <= FREE;
                    else if (hs && sel == FU_W'(k))
                        st[k] <= ISSUED;
                    if (st[k] == WAIT && wb_en && q1_q[k] == wb_fu)
                        r1_q[k] <= 1'b1;
                    if (st[k] == WAIT && wb_en && q2_q[k] == wb_fu)
                        r2_q[k] <= 1'b1;
                end
            end
            if (hs)
                rr_ptr <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_fust_issue_table.sv
// Bench for fust_issue_table: directed vector table, reset corner case,
// then random traffic against a row-level reference model.
module tb_fust_issue_table;

    localparam int NUM_FU = 4;
    localparam int OP_W   = 5;
    localparam int REG_W  = 5;
    localparam int FU_W   = 2;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic disp_en = 0;
    logic [FU_W-1:0] disp_fu = 0;
    logic [OP_W-1:0] disp_op = 0;
    logic [REG_W-1:0] disp_rd = 0, disp_rs1 = 0, disp_rs2 = 0;
    logic [FU_W-1:0] disp_q1 = 0, disp_q2 = 0;
    logic disp_r1 = 0, disp_r2 = 0;
    logic [NUM_FU-1:0] busy;
    logic wb_en = 0;
    logic [FU_W-1:0] wb_fu = 0;
    logic flush = 0, freeze = 0;
    logic iss_valid;
    logic iss_ready = 0;
    logic [FU_W-1:0] iss_fu;
    logic [OP_W-1:0] iss_op;
    logic [REG_W-1:0] iss_rd, iss_rs1, iss_rs2;

    fust_issue_table #(
        .NUM_FU(NUM_FU),
        .OP_W(OP_W),
        .REG_W(REG_W)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .disp_en(disp_en),
        .disp_fu(disp_fu),
        .disp_op(disp_op),
        .disp_rd(disp_rd),
        .disp_rs1(disp_rs1),
        .disp_rs2(disp_rs2),
        .disp_q1(disp_q1),
        .disp_q2(disp_q2),
        .disp_r1(disp_r1),
        .disp_r2(disp_r2),
        .busy(busy),
        .wb_en(wb_en),
        .wb_fu(wb_fu),
        .flush(flush),
        .freeze(freeze),
        .iss_valid(iss_valid),
        .iss_ready(iss_ready),
        .iss_fu(iss_fu),
        .iss_op(iss_op),
        .iss_rd(iss_rd),
        .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic de;
        logic [1:0] dfu;
        logic [4:0] dop;
        logic [1:0] q1, q2;
        logic r1, r2;
        logic we;
        logic [1:0] wfu;
        logic fl, fz, rdy;
        logic [3:0] e_busy;
        logic e_val;
        logic [1:0] e_fu;
        logic [4:0] e_op;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic de, logic [1:0] dfu, logic [4:0] dop,
        logic [1:0] q1, logic [1:0] q2, logic r1, logic r2,
        logic we, logic [1:0] wfu, logic fl, logic fz, logic rdy,
        logic [3:0] eb, logic ev, logic [1:0] efu, logic [4:0] eop);
        vec_t v;
        v.de = de; v.dfu = dfu; v.dop = dop;
        v.q1 = q1; v.q2 = q2; v.r1 = r1; v.r2 = r2;
        v.we = we; v.wfu = wfu; v.fl = fl; v.fz = fz; v.rdy = rdy;
        v.e_busy = eb; v.e_val = ev; v.e_fu = efu; v.e_op = eop;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per FU row
    int m_st[NUM_FU];
    logic [4:0] m_op[NUM_FU], m_rd[NUM_FU], m_rs1[NUM_FU], m_rs2[NUM_FU];
    int m_q1[NUM_FU], m_q2[NUM_FU];
    bit m_r1[NUM_FU], m_r2[NUM_FU];
    int m_ptr;

    function automatic void m_reset();
        for (int k = 0; k < NUM_FU; k++) begin
            m_st[k] = 0; m_op[k] = 0; m_rd[k] = 0;
            m_rs1[k] = 0; m_rs2[k] = 0;
            m_q1[k] = 0; m_q2[k] = 0; m_r1[k] = 0; m_r2[k] = 0;
        end
        m_ptr = 0;
    endfunction

    function automatic void m_pick(output bit v, output int s);
        v = 0;
        s = 0;
        if (!flush && !freeze)
            for (int i = 0; i < NUM_FU; i++) begin
                int j;
                j = (m_ptr + i) % NUM_FU;
                if (!v && m_st[j] == 1 && m_r1[j] && m_r2[j]) begin
                    v = 1;
                    s = j;
                end
            end
    endfunction

    function automatic void m_step(bit v, int s);
        int old[NUM_FU];
        bit hsk;
        if (flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                m_st[k] = 0; m_r1[k] = 0; m_r2[k] = 0;
            end
            m_ptr = 0;
            return;
        end
        hsk = v && iss_ready;
        for (int k = 0; k < NUM_FU; k++) old[k] = m_st[k];
        for (int k = 0; k < NUM_FU; k++) begin
            bit frees;
            frees = wb_en && int'(wb_fu) == k && old[k] == 2;
            if (old[k] == 1 && wb_en && m_q1[k] == int'(wb_fu)) m_r1[k] = 1;
            if (old[k] == 1 && wb_en && m_q2[k] == int'(wb_fu)) m_r2[k] = 1;
            if (hsk && s == k) m_st[k] = 2;
            if (frees) m_st[k] = 0;
            if (disp_en && !freeze && int'(disp_fu) == k
                && (old[k] == 0 || frees)) begin
                m_st[k] = 1;
                m_op[k] = disp_op; m_rd[k] = disp_rd;
                m_rs1[k] = disp_rs1; m_rs2[k] = disp_rs2;
                m_q1[k] = int'(disp_q1); m_q2[k] = int'(disp_q2);
                m_r1[k] = disp_r1 || (wb_en && disp_q1 == wb_fu);
                m_r2[k] = disp_r2 || (wb_en && disp_q2 == wb_fu);
            end
        end
        if (hsk) m_ptr = (s + 1) % NUM_FU;
    endfunction

    task automatic idle_inputs();
        disp_en = 0; disp_fu = 0; disp_op = 0;
        disp_rd = 0; disp_rs1 = 0; disp_rs2 = 0;
        disp_q1 = 0; disp_q2 = 0; disp_r1 = 0; disp_r2 = 0;
        wb_en = 0; wb_fu = 0; flush = 0; freeze = 0; iss_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        // busy, valid, fu, op expected before each edge
        tbl.push_back(mk(1,1,5'h11,0,0,1,1,0,0,0,0,1, 4'b0000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b0010,1,1,5'h11));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,1,    4'b0010,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b0000,0,0,0));
        tbl.push_back(mk(1,2,5'h12,0,0,0,1,0,0,0,0,1, 4'b0000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b0100,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,1,    4'b0100,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b0100,1,2,5'h12));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,2,0,0,1,    4'b0100,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0,    4'b0000,0,0,0));
        tbl.push_back(mk(1,0,5'h10,0,0,1,1,0,0,0,0,0, 4'b0000,0,0,0));
        tbl.push_back(mk(1,1,5'h11,0,0,1,1,0,0,0,0,0, 4'b0001,1,0,5'h10));
        tbl.push_back(mk(1,3,5'h13,0,0,1,1,0,0,0,0,0, 4'b0011,1,0,5'h10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1011,1,0,5'h10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1011,1,1,5'h11));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,1,    4'b1011,1,3,5'h13));
        tbl.push_back(mk(1,0,5'h14,0,0,1,1,1,1,0,0,1, 4'b1010,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1001,1,0,5'h14));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,1,    4'b1001,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,3,0,0,1,    4'b1000,0,0,0));
        tbl.push_back(mk(1,2,5'h12,0,3,1,0,1,3,0,0,1, 4'b0000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b0100,1,2,5'h12));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,2,0,0,1,    4'b0100,0,0,0));
        tbl.push_back(mk(1,1,5'h11,0,0,1,1,0,0,0,0,0, 4'b0000,0,0,0));
        tbl.push_back(mk(1,2,5'h12,0,0,1,1,0,0,0,0,0, 4'b0010,1,1,5'h11));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,1,    4'b0110,0,0,0));
        tbl.push_back(mk(1,3,5'h13,0,0,1,1,0,0,0,0,0, 4'b0000,0,0,0));
        tbl.push_back(mk(1,1,5'h11,0,0,1,1,0,0,0,0,0, 4'b1000,1,3,5'h13));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,    4'b1010,1,1,5'h11));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,    4'b1010,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1010,1,1,5'h11));
        tbl.push_back(mk(1,1,5'h15,0,0,1,1,1,1,0,1,1, 4'b1010,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,    4'b1000,1,3,5'h13));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1000,1,3,5'h13));
        tbl.push_back(mk(1,3,5'h16,0,0,1,1,1,3,0,0,0, 4'b1000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,    4'b1000,1,3,5'h16));
        tbl.push_back(mk(1,3,5'h17,0,0,1,1,0,0,0,0,0, 4'b1000,1,3,5'h16));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,    4'b1000,1,3,5'h16));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,3,0,0,1,    4'b1000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,    4'b0000,0,0,0));

        idle_inputs();
        nRST = 0;
        #1;
        check("reset_outputs",
              {busy, iss_valid, iss_fu, iss_op, iss_rd, iss_rs1, iss_rs2},
              32'h0);
        do_reset();

        foreach (tbl[i]) begin
            disp_en = tbl[i].de; disp_fu = tbl[i].dfu; disp_op = tbl[i].dop;
            disp_rd = tbl[i].dop; disp_rs1 = tbl[i].dop ^ 5'h3;
            disp_rs2 = tbl[i].dop ^ 5'h5;
            disp_q1 = tbl[i].q1; disp_q2 = tbl[i].q2;
            disp_r1 = tbl[i].r1; disp_r2 = tbl[i].r2;
            wb_en = tbl[i].we; wb_fu = tbl[i].wfu;
            flush = tbl[i].fl; freeze = tbl[i].fz; iss_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d", i),
                  {busy, iss_valid, iss_fu, iss_op},
                  {tbl[i].e_busy, tbl[i].e_val, tbl[i].e_fu, tbl[i].e_op});
            @(posedge CLK);
            @(negedge CLK);
        end

        // Async reset in the middle of an issue handshake
        idle_inputs();
        disp_en = 1; disp_fu = 1; disp_op = 5'h11;
        disp_rd = 5'h07; disp_r1 = 1; disp_r2 = 1;
        @(negedge CLK);
        idle_inputs();
        iss_ready = 1;
        #1;
        check("pre_reset_issue", {busy, iss_valid, iss_fu, iss_op},
              {4'b0010, 1'b1, 2'd1, 5'h11});
        #1;
        nRST = 0;
        #1;
        check("async_reset",
              {busy, iss_valid, iss_fu, iss_op, iss_rd, iss_rs1, iss_rs2},
              32'h0);
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        disp_en = 1; disp_fu = 2; disp_op = 5'h12; disp_r1 = 1; disp_r2 = 1;
        #1;
        check("post_reset_empty", {busy, iss_valid}, {4'b0000, 1'b0});
        @(negedge CLK);
        idle_inputs();
        #1;
        check("post_reset_disp", {busy, iss_valid, iss_fu, iss_op},
              {4'b0100, 1'b1, 2'd2, 5'h12});

        // Random traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v;
            int s;
            logic [3:0] eb;
            disp_en = ($urandom_range(1) == 1);
            disp_fu = 2'($urandom_range(3));
            disp_op = 5'($urandom);
            disp_rd = 5'($urandom);
            disp_rs1 = 5'($urandom);
            disp_rs2 = 5'($urandom);
            disp_q1 = 2'($urandom_range(3));
            disp_q2 = 2'($urandom_range(3));
            disp_r1 = ($urandom_range(2) != 0);
            disp_r2 = ($urandom_range(2) != 0);
            wb_en = ($urandom_range(1) == 1);
            wb_fu = 2'($urandom_range(3));
            flush = ($urandom_range(31) == 0);
            freeze = ($urandom_range(7) == 0);
            iss_ready = ($urandom_range(2) != 0);
            #1;
            m_pick(v, s);
            for (int k = 0; k < NUM_FU; k++) eb[k] = (m_st[k] != 0);
            if (v)
                check($sformatf("rand%0d", c),
                      {busy, iss_valid, iss_fu, iss_op, iss_rd, iss_rs1, iss_rs2},
                      {eb, 1'b1, 2'(s), m_op[s], m_rd[s], m_rs1[s], m_rs2[s]});
            else
                check($sformatf("rand%0d", c),
                      {busy, iss_valid, iss_fu, iss_op, iss_rd, iss_rs1, iss_rs2},
                      {eb, 1'b0, 2'd0, 20'd0});
            @(posedge CLK);
            m_step(v, s);
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
